// File: rtl/reg_arb_pkg.sv
// Shared definitions for the round-robin register access arbiter:
// operation codes, FSM state encoding and owner index sizing.
package reg_arb_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // An owner index needs at least one bit even for two requesters.
    function automatic int owner_width(input int n_req);
        return (n_req > 2) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/shared_reg.sv
// Shared D flip-flop register with one-hot set, clear and load strobes;
// holds its value when no strobe is active.
module shared_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             set_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_reg <= '0;
        end else if (set_i) begin
            q_reg <= '1;
        end else if (clr_i) begin
            q_reg <= '0;
        end else if (load_i) begin
            q_reg <= d_i;
        end
    end

    assign q_o = q_reg;

endmodule

// File: rtl/reg_access_arb.sv
// Round-robin arbiter granting one requester per clock to operate on a shared
// register, with optional bounded locked bursts for the current owner.
module reg_access_arb
    import reg_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_LOCK = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [N_REQ-1:0]                     req_i,
    input  logic [N_REQ-1:0]                     lock_i,
    input  logic [2*N_REQ-1:0]                   op_i,
    input  logic [WIDTH*N_REQ-1:0]               d_i,
    output logic [N_REQ-1:0]                     gnt_o,
    output logic [WIDTH-1:0]                     Q,
    output logic [owner_width(N_REQ)-1:0]        owner_o,
    output logic                                 locked_o
);

    localparam int OW = owner_width(N_REQ);
    localparam int CW = $clog2(MAX_LOCK + 1);

    logic [1:0]       op_arr [N_REQ];
    logic [WIDTH-1:0] d_arr  [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign op_arr[gi] = op_i[2*gi +: 2];
            assign d_arr[gi]  = d_i[WIDTH*gi +: WIDTH];
        end
    endgenerate

    arb_state_t       state_reg;
    logic [N_REQ-1:0] gnt_reg;
    logic [OW-1:0]    owner_reg;
    logic [OW-1:0]    ptr_reg;
    logic [CW-1:0]    cnt_reg;

    logic          found;
    logic [OW-1:0] win_idx;
    logic [OW-1:0] scan_idx;
    int            scan_int;

    // Rotating scan starting at ptr; the first requester found wins.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        scan_int = 0;
        scan_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_int = int'(ptr_reg) + i;
            if (scan_int >= N_REQ) begin
                scan_int = scan_int - N_REQ;
            end
            scan_idx = OW'(scan_int);
            if (!found && req_i[scan_idx]) begin
                found   = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    logic          grant_valid;
    logic [OW-1:0] grant_idx;
    logic [1:0]    grant_op;

    always_comb begin
        if (state_reg == ST_LOCKED) begin
            grant_valid = req_i[owner_reg];
            grant_idx   = owner_reg;
        end else begin
            grant_valid = found;
            grant_idx   = win_idx;
        end
        grant_op = op_arr[grant_idx];
    end

    logic load_stb;
    logic set_stb;
    logic clr_stb;

    assign load_stb = grant_valid && (grant_op == OP_LOAD);
    assign set_stb  = grant_valid && (grant_op == OP_SET);
    assign clr_stb  = grant_valid && (grant_op == OP_CLR);

    shared_reg #(
        .WIDTH(WIDTH)
    ) u_shared_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .set_i (set_stb),
        .clr_i (clr_stb),
        .load_i(load_stb),
        .d_i   (d_arr[grant_idx]),
        .q_o   (Q)
    );

    logic [N_REQ-1:0] grant_onehot;
    assign grant_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_ARB;
            gnt_reg   <= '0;
            owner_reg <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_ARB: begin
                    if (found) begin
                        gnt_reg   <= grant_onehot;
                        owner_reg <= win_idx;
                        ptr_reg   <= (win_idx == OW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                        cnt_reg   <= CW'(1);
                        state_reg <= (lock_i[win_idx] && (MAX_LOCK > 1)) ? ST_LOCKED : ST_ARB;
                    end else begin
                        gnt_reg <= '0;
                    end
                end
                ST_LOCKED: begin
                    // ptr stays put so arbitration resumes just past the owner.
                    if (req_i[owner_reg]) begin
                        gnt_reg   <= grant_onehot;
                        cnt_reg   <= cnt_reg + 1'b1;
                        state_reg <= (lock_i[owner_reg] && ((int'(cnt_reg) + 1) < MAX_LOCK))
                                     ? ST_LOCKED : ST_ARB;
                    end else begin
                        gnt_reg   <= '0;
                        state_reg <= ST_ARB;
                    end
                end
                default: begin
                    state_reg <= ST_ARB;
                    gnt_reg   <= '0;
                end
            endcase
        end
    end

    assign gnt_o    = gnt_reg;
    assign owner_o  = owner_reg;
    assign locked_o = (state_reg == ST_LOCKED);

endmodule
